c2h_stream_arbiter: RTL



---
 rtl/c2h_stream_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/c2h_stream_arbiter.sv
// Packet-granular round-robin arbiter that shares one AXI-Stream C2H channel among NUM_CH requesters.
// Optional per-channel packet counters are enabled with `define C2H_ARB_PKT_CNT_EN.
module c2h_stream_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH*DATA_W-1:0]     s_tdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0] s_tkeep,
    input  logic [NUM_CH-1:0]            s_tlast,
    input  logic [NUM_CH-1:0]            s_tvalid,
    output logic [NUM_CH-1:0]            s_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic [DATA_W/8-1:0]          m_tkeep,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [NUM_CH-1:0]            grant,
    output logic                         busy
`ifdef C2H_ARB_PKT_CNT_EN
    ,
    output logic [NUM_CH*32-1:0]         pkt_cnt,
    input  logic                         pkt_cnt_clr
`endif
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned PTR_W  = $clog2(NUM_CH);

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_owner;

    logic                w_load;
    logic                w_accept;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [DATA_W-1:0]   w_sel_data;
    logic [KEEP_W-1:0]   w_sel_keep;
    logic [NUM_CH-1:0]   w_cand;
    logic                w_pick_valid;
    logic [PTR_W-1:0]    w_pick_idx;
    logic [PTR_W-1:0]    w_scan_idx;
    logic [PTR_W-1:0]    w_next_ptr;

    // Output register may take a new beat when empty or being drained this cycle.
    assign w_load      = !m_tvalid || m_tready;
    assign s_tready    = grant & {NUM_CH{w_load}};

    assign w_sel_valid = s_tvalid[r_owner];
    assign w_sel_last  = s_tlast[r_owner];
    assign w_sel_data  = s_tdata[32'(r_owner)*DATA_W +: DATA_W];
    assign w_sel_keep  = s_tkeep[32'(r_owner)*KEEP_W +: KEEP_W];
    assign w_accept    = (r_state == ST_LOCK) && w_sel_valid && w_load;

    assign w_cand      = s_tvalid & ch_en;
    assign w_next_ptr  = PTR_W'((32'(r_owner) + 32'd1) % NUM_CH);

    // First candidate at or after rr_ptr; scanning downwards lets the nearest one win.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_scan_idx = PTR_W'((32'(r_rr_ptr) + 32'(k)) % NUM_CH);
            if (w_cand[w_scan_idx]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            if (w_accept) begin
                m_tdata  <= w_sel_data;
                m_tkeep  <= w_sel_keep;
                m_tlast  <= w_sel_last;
                m_tvalid <= 1'b1;
            end else if (w_load) begin
                m_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        grant   <= NUM_CH'(1) << w_pick_idx;
                        r_owner <= w_pick_idx;
                        busy    <= 1'b1;
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_accept && w_sel_last) begin
                        grant    <= '0;
                        busy     <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef C2H_ARB_PKT_CNT_EN
    logic [31:0] r_pkt_cnt [NUM_CH];

    // Clear takes priority over a coincident tlast increment.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || pkt_cnt_clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else if (w_accept && w_sel_last) begin
            r_pkt_cnt[r_owner] <= r_pkt_cnt[r_owner] + 32'd1;
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pkt_cnt[i*32 +: 32] = r_pkt_cnt[i];
        end
    end
`endif

endmodule
